regfile_port_arbiter: RTL

- Shares one register_block instance (2 read ports, 1 write port, NUM_LANES lanes, one shared warp_selector) between NUM_REQ operand-read requesters and one writeback requester.
- Each cycle it grants at most one read request and one writeback, then drives the register_block control pins.
- It captures the combinational read data into a registered response.
- It sits between the issue/operand-collect stage and the register file.

---
 rtl/regfile_port_arbiter_if.sv | 64 ++++++
 rtl/regfile_port_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/regfile_port_arbiter_if.sv
// Bundle of the requester-facing and register_block-facing signals of the
// register-file port arbiter. The slave modport is the arbiter's view; the
// master modport is the surrounding pipeline plus register_block.
interface regfile_port_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_LANES = 16,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int WARP_W    = 3,
  parameter int ID_W      = $clog2(NUM_REQ)
);
  // operand-read requests
  logic [NUM_REQ-1:0]           rd_req_valid;
  logic [NUM_REQ-1:0]           rd_req_ready;
  logic [NUM_REQ*WARP_W-1:0]    rd_req_warp;
  logic [NUM_REQ*ADDR_W-1:0]    rd_req_addr0;
  logic [NUM_REQ*ADDR_W-1:0]    rd_req_addr1;
  logic [NUM_REQ*NUM_LANES-1:0] rd_req_mask;
  // registered read response
  logic                         rd_rsp_valid;
  logic [ID_W-1:0]              rd_rsp_id;
  logic [NUM_LANES*DATA_W-1:0]  rd_rsp_data0;
  logic [NUM_LANES*DATA_W-1:0]  rd_rsp_data1;
  // writeback request
  logic                         wb_valid;
  logic                         wb_ready;
  logic [WARP_W-1:0]            wb_warp;
  logic [ADDR_W-1:0]            wb_addr;
  logic [NUM_LANES-1:0]         wb_mask;
  logic [NUM_LANES*DATA_W-1:0]  wb_data;
  // register_block control and data
  logic [NUM_LANES-1:0]         rf_read_en_0;
  logic [NUM_LANES-1:0]         rf_read_en_1;
  logic [ADDR_W-1:0]            rf_raddr_0;
  logic [ADDR_W-1:0]            rf_raddr_1;
  logic [NUM_LANES-1:0]         rf_write_en;
  logic [ADDR_W-1:0]            rf_waddr;
  logic [NUM_LANES*DATA_W-1:0]  rf_wdata;
  logic [WARP_W-1:0]            rf_warp_selector;
  logic [NUM_LANES*DATA_W-1:0]  rf_rdata_0;
  logic [NUM_LANES*DATA_W-1:0]  rf_rdata_1;

  modport slave (
    input  rd_req_valid, rd_req_warp, rd_req_addr0, rd_req_addr1, rd_req_mask,
    output rd_req_ready,
    output rd_rsp_valid, rd_rsp_id, rd_rsp_data0, rd_rsp_data1,
    input  wb_valid, wb_warp, wb_addr, wb_mask, wb_data,
    output wb_ready,
    output rf_read_en_0, rf_read_en_1, rf_raddr_0, rf_raddr_1,
    output rf_write_en, rf_waddr, rf_wdata, rf_warp_selector,
    input  rf_rdata_0, rf_rdata_1
  );

  modport master (
    output rd_req_valid, rd_req_warp, rd_req_addr0, rd_req_addr1, rd_req_mask,
    input  rd_req_ready,
    input  rd_rsp_valid, rd_rsp_id, rd_rsp_data0, rd_rsp_data1,
    output wb_valid, wb_warp, wb_addr, wb_mask, wb_data,
    input  wb_ready,
    input  rf_read_en_0, rf_read_en_1, rf_raddr_0, rf_raddr_1,
    input  rf_write_en, rf_waddr, rf_wdata, rf_warp_selector,
    output rf_rdata_0, rf_rdata_1
  );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Shares one register_block (2 read ports, 1 write port, one warp selector)
// between NUM_REQ operand-read requesters and a single writeback requester.
// Per cycle: at most one read and one write, both on the same warp. Writes
// normally win the warp, but a different-warp read that has waited through
// MAX_WB_STREAK write cycles forces one cycle for reads. Read data is
// captured into a one-cycle registered response with inactive lanes zeroed.
module regfile_port_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int NUM_LANES     = 16,
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5,
  parameter int WARP_W        = 3,
  parameter int MAX_WB_STREAK = 4,
  parameter int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_port_arbiter_if.slave bus
);

  localparam int STREAK_W = $clog2(MAX_WB_STREAK + 1);
  localparam int BUS_W    = NUM_LANES * DATA_W;

  // Requester index reached by stepping ofs positions from base, cyclically.
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int ofs);
    return ID_W'((int'(base) + ofs) % NUM_REQ);
  endfunction

  // Zero every lane whose mask bit is clear.
  function automatic logic [BUS_W-1:0] mask_lanes(input logic [BUS_W-1:0] data,
                                                  input logic [NUM_LANES-1:0] mask);
    logic [BUS_W-1:0] res;
    res = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (mask[l]) res[l*DATA_W +: DATA_W] = data[l*DATA_W +: DATA_W];
    end
    return res;
  endfunction

  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [STREAK_W-1:0] wb_streak_q, wb_streak_d;
  logic [WARP_W-1:0]   last_warp_q, last_warp_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [BUS_W-1:0]    rsp_data0_q, rsp_data0_d;
  logic [BUS_W-1:0]    rsp_data1_q, rsp_data1_d;

  logic [WARP_W-1:0]    req_warp  [NUM_REQ];
  logic [ADDR_W-1:0]    req_addr0 [NUM_REQ];
  logic [ADDR_W-1:0]    req_addr1 [NUM_REQ];
  logic [NUM_LANES-1:0] req_mask  [NUM_REQ];

  logic                pending_any;
  logic                pending_diff;
  logic                wb_grant;
  logic                rr_found;
  logic [ID_W-1:0]     rr_win;
  logic [WARP_W-1:0]   cur_warp;
  logic                rd_grant;
  logic [ID_W-1:0]     rd_win;
  logic [NUM_REQ-1:0]  rd_ready_vec;

  // Unpack the flat per-requester buses into indexable arrays.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_warp[i]  = bus.rd_req_warp[i*WARP_W +: WARP_W];
      req_addr0[i] = bus.rd_req_addr0[i*ADDR_W +: ADDR_W];
      req_addr1[i] = bus.rd_req_addr1[i*ADDR_W +: ADDR_W];
      req_mask[i]  = bus.rd_req_mask[i*NUM_LANES +: NUM_LANES];
    end
  end

  // Pick the cycle's warp, grant the write and at most one read, and compute next state.
  always_comb begin
    pending_any  = 1'b0;
    pending_diff = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.rd_req_valid[i]) begin
        pending_any = 1'b1;
        if (req_warp[i] != bus.wb_warp) pending_diff = 1'b1;
      end
    end

    // The write yields only when its streak is exhausted and a read on another warp waits.
    wb_grant = !rst && bus.wb_valid &&
               ((wb_streak_q < STREAK_W'(MAX_WB_STREAK)) || !pending_diff);

    rr_found = 1'b0;
    rr_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!rr_found && bus.rd_req_valid[wrap_idx(rr_ptr_q, k)]) begin
        rr_found = 1'b1;
        rr_win   = wrap_idx(rr_ptr_q, k);
      end
    end

    if (wb_grant)      cur_warp = bus.wb_warp;
    else if (rr_found) cur_warp = req_warp[rr_win];
    else               cur_warp = last_warp_q;

    // A read touching the register being written this cycle waits one cycle for the new value.
    rd_grant = 1'b0;
    rd_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!rst && !rd_grant && bus.rd_req_valid[wrap_idx(rr_ptr_q, k)] &&
          req_warp[wrap_idx(rr_ptr_q, k)] == cur_warp &&
          !(wb_grant && (req_addr0[wrap_idx(rr_ptr_q, k)] == bus.wb_addr ||
                         req_addr1[wrap_idx(rr_ptr_q, k)] == bus.wb_addr))) begin
        rd_grant = 1'b1;
        rd_win   = wrap_idx(rr_ptr_q, k);
      end
    end

    rd_ready_vec = '0;
    if (rd_grant) rd_ready_vec[rd_win] = 1'b1;

    rr_ptr_d = rd_grant ? wrap_idx(rd_win, 1) : rr_ptr_q;

    if (!wb_grant)
      wb_streak_d = '0;
    else if (pending_diff && (wb_streak_q < STREAK_W'(MAX_WB_STREAK)))
      wb_streak_d = wb_streak_q + STREAK_W'(1);
    else
      wb_streak_d = wb_streak_q;

    last_warp_d = cur_warp;

    rsp_valid_d = rd_grant;
    rsp_id_d    = rd_grant ? rd_win : rsp_id_q;
    rsp_data0_d = rd_grant ? mask_lanes(bus.rf_rdata_0, req_mask[rd_win]) : rsp_data0_q;
    rsp_data1_d = rd_grant ? mask_lanes(bus.rf_rdata_1, req_mask[rd_win]) : rsp_data1_q;
  end

  // Arbitration state and the registered read response; reset drops any in-flight response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      wb_streak_q <= '0;
      last_warp_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data0_q <= '0;
      rsp_data1_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wb_streak_q <= wb_streak_d;
      last_warp_q <= last_warp_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data0_q <= rsp_data0_d;
      rsp_data1_q <= rsp_data1_d;
    end
  end

  assign bus.rd_req_ready     = rd_ready_vec;
  assign bus.wb_ready         = wb_grant;
  assign bus.rf_warp_selector = cur_warp;
  assign bus.rf_read_en_0     = rd_grant ? req_mask[rd_win]  : '0;
  assign bus.rf_read_en_1     = rd_grant ? req_mask[rd_win]  : '0;
  assign bus.rf_raddr_0       = rd_grant ? req_addr0[rd_win] : '0;
  assign bus.rf_raddr_1       = rd_grant ? req_addr1[rd_win] : '0;
  assign bus.rf_write_en      = wb_grant ? bus.wb_mask : '0;
  assign bus.rf_waddr         = wb_grant ? bus.wb_addr : '0;
  assign bus.rf_wdata         = wb_grant ? bus.wb_data : '0;

  assign bus.rd_rsp_valid = rsp_valid_q;
  assign bus.rd_rsp_id    = rsp_id_q;
  assign bus.rd_rsp_data0 = rsp_data0_q;
  assign bus.rd_rsp_data1 = rsp_data1_q;

endmodule
